gtx_lane_checker: RTL and testbench
===================================

GTX_LANE_CHECKER -- requirements
Module: gtx_lane_checker

Interface
REQ-001 SHALL have parameter LOCK_WORDS, default 16: consecutive correct data words required to declare lock.
REQ-002 SHALL have parameter LOSS_WORDS, default 4: consecutive bad data words that force loss of lock.
REQ-003 SHALL have port clk, input, 1: GTX RXUSRCLK2 domain clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port rx_data, input, 16: GTX RXDATA; byte 0 = [7:0].
REQ-006 SHALL have port rx_charisk, input, 2: per-byte K-character flag.
REQ-007 SHALL have port rx_disperr, input, 2: per-byte disparity error.
REQ-008 SHALL have port rx_notintable, input, 2: per-byte not-in-table error.
REQ-009 SHALL have port rx_resetdone, input, 1: GTX RX reset complete; low means lane not usable.
REQ-010 SHALL have port clr_counts, input, 1: single-cycle pulse that clears all counters.
REQ-011 SHALL have port locked, output, 1: high while in LOCKED state.
REQ-012 SHALL have port state, output, 2: HUNT=0, SYNC=1, LOCKED=2.
REQ-013 SHALL have port word_count, output, 32: data words checked while LOCKED.
REQ-014 SHALL have port err_count, output, 32: mismatched data words while LOCKED.
REQ-015 SHALL have port loss_count, output, 16: LOCKED-to-HUNT transitions.
REQ-016 SHALL have port code_err_count, output, 32: words with any disparity or not-in-table error.

Function
REQ-017 SHALL classify a word as comma when rx_charisk=2'b01 and rx_data=16'h50BC (K28.5 low, D16.2 high).
REQ-018 SHALL classify a word as data when rx_charisk=2'b00; any other rx_charisk value is a bad word.
REQ-019 SHALL treat commas as idle fill: they never advance the expected value and never count as good or bad.
REQ-020 SHALL check the data pattern as a 16-bit incrementing counter, where each data word equals the previous expected value + 1, mod 2^16, wrapping 16'hFFFF to 16'h0000.
REQ-021 HUNT: on a comma, go to SYNC; all other words are ignored.
REQ-022 SYNC, first data word after entry: seed expected <= rx_data+1 and set the good-run counter to 1.
REQ-023 SYNC, subsequent data words: on match, increment the good run and advance expected; on mismatch or bad word, return to HUNT.
REQ-024 SYNC: when the good run reaches LOCK_WORDS, go to LOCKED; locked SHALL rise on the cycle after the LOCK_WORDS-th good word is registered.
REQ-025 LOCKED, every data word or bad word: increment word_count.
REQ-026 LOCKED, mismatch or bad word: increment err_count and the bad-run counter.
REQ-027 LOCKED, correct word: clear the bad-run counter.
REQ-028 LOCKED: expected SHALL advance by 1 on every data word, matching or not, so a single corrupted word costs exactly one error.
REQ-029 LOCKED: when the bad run reaches LOSS_WORDS, go to HUNT and increment loss_count.
REQ-030 SHALL make counter updates visible one cycle after the word is presented, with no other pipeline latency.
REQ-031 SHALL saturate all counters at their all-ones value, with no wrap.
REQ-032 rx_resetdone low SHALL force HUNT on the next cycle from any state; if leaving LOCKED this way, increment loss_count.
REQ-033 clr_counts SHALL zero all counters on the next cycle without affecting state or expected; clear wins over a simultaneous increment.

Reset
REQ-034 rst high SHALL, on the next clock edge, set state=HUNT, locked=0, all counters=0, expected=0, run counters=0; it takes priority over all other inputs, including mid-lock.

Configuration
REQ-035 With macro GTX_LANE_CHECKER_CODEERR_EN defined: any set bit of rx_disperr or rx_notintable SHALL make that word bad (in any state) and SHALL increment code_err_count, regardless of state.
REQ-036 Without GTX_LANE_CHECKER_CODEERR_EN: rx_disperr and rx_notintable SHALL be ignored and code_err_count SHALL be tied to 0.

Verification
REQ-037 Sequence: rst, then comma, then data 16'h0000..16'h0013 -> locked rises on the cycle after 16'h000F; word_count=4 and err_count=0 after 16'h0013.
REQ-038 When locked, replace 16'h0100 with 16'h1234, then continue the normal count -> err_count=1, locked stays 1, loss_count=0.
REQ-039 When locked, skip four values (slip) -> err_count increments by 4, state=HUNT, loss_count=1; a following comma plus 16 good words relocks.
REQ-040 Lock, then run through 16'hFFFF followed by 16'h0000 -> no error at the wrap.
REQ-041 When locked, drive rx_resetdone=0 for 1 cycle -> state=HUNT next cycle, loss_count=1; in the same run, assert clr_counts together with an error word -> all counters read 0.
REQ-042 With GTX_LANE_CHECKER_CODEERR_EN and locked, a word with rx_disperr=2'b10 and correct data -> err_count+1 and code_err_count+1; without the macro -> no change.

Source files
------------

// File: rtl/gtx_lane_checker.sv
// gtx_lane_checker: lock/loss tracker and error counters for an incrementing 16-bit GTX test pattern.
// Define GTX_LANE_CHECKER_CODEERR_EN to treat disparity/not-in-table errors as bad words and count them.
module gtx_lane_checker #(
  parameter int LOCK_WORDS = 16,
  parameter int LOSS_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rx_data,
  input  logic [1:0]  rx_charisk,
  input  logic [1:0]  rx_disperr,
  input  logic [1:0]  rx_notintable,
  input  logic        rx_resetdone,
  input  logic        clr_counts,
  output logic        locked,
  output logic [1:0]  state,
  output logic [31:0] word_count,
  output logic [31:0] err_count,
  output logic [15:0] loss_count,
  output logic [31:0] code_err_count
);
  typedef enum logic [1:0] {HUNT = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;
  state_t state_q, state_d;
  logic [15:0] exp_q, exp_d, good_q, good_d, bad_q, bad_d, loss_q, loss_d;
  logic seeded_q, seeded_d;
  logic [31:0] word_q, word_d, err_q, err_d, code_q, code_d;
  logic code_err, data_shape, is_comma, is_data, is_bad, inc_word, inc_err, inc_loss;
`ifdef GTX_LANE_CHECKER_CODEERR_EN
  assign code_err = |{rx_disperr, rx_notintable};
`else
  logic unused_code;
  assign unused_code = ^{rx_disperr, rx_notintable};
  assign code_err = 1'b0;
`endif
  assign data_shape = rx_charisk == 2'b00;
  assign is_comma = rx_charisk == 2'b01 && rx_data == 16'h50BC && !code_err;
  assign is_data = data_shape && !code_err;
  assign is_bad = !is_comma && !is_data;
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    good_d = good_q;
    bad_d = bad_q;
    seeded_d = seeded_q;
    inc_word = 1'b0;
    inc_err = 1'b0;
    inc_loss = 1'b0;
    if (!rx_resetdone) begin
      state_d = HUNT;
      good_d = '0;
      bad_d = '0;
      seeded_d = 1'b0;
      inc_loss = state_q == LOCKED;
    end else if (state_q == HUNT) begin
      if (is_comma) begin
        state_d = SYNC;
        good_d = '0;
        seeded_d = 1'b0;
      end
    end else if (state_q == SYNC) begin
      if (is_bad || (is_data && seeded_q && rx_data != exp_q)) begin
        state_d = HUNT;
        good_d = '0;
        seeded_d = 1'b0;
      end else if (is_data) begin
        // the first word seeds; later ones match exp_q, so rx_data+1 is the next expected either way
        exp_d = rx_data + 16'd1;
        good_d = seeded_q ? good_q + 16'd1 : 16'd1;
        seeded_d = 1'b1;
        if (good_d == 16'(LOCK_WORDS)) begin
          state_d = LOCKED;
          bad_d = '0;
        end
      end
    end else begin
      // any data-shaped word advances expected, so one corrupted word costs one error
      if (data_shape) exp_d = exp_q + 16'd1;
      if (!is_comma) begin
        inc_word = 1'b1;
        inc_err = is_bad || rx_data != exp_q;
        bad_d = inc_err ? bad_q + 16'd1 : 16'd0;
        if (inc_err && bad_d >= 16'(LOSS_WORDS)) begin
          state_d = HUNT;
          inc_loss = 1'b1;
          bad_d = '0;
          good_d = '0;
          seeded_d = 1'b0;
        end
      end
    end
    word_d = clr_counts ? '0 : word_q + 32'(inc_word && ~&word_q);
    err_d = clr_counts ? '0 : err_q + 32'(inc_err && ~&err_q);
    loss_d = clr_counts ? '0 : loss_q + 16'(inc_loss && ~&loss_q);
    code_d = clr_counts ? '0 : code_q + 32'(code_err && ~&code_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HUNT;
      exp_q <= '0;
      good_q <= '0;
      bad_q <= '0;
      seeded_q <= 1'b0;
      word_q <= '0;
      err_q <= '0;
      loss_q <= '0;
      code_q <= '0;
    end else begin
      state_q <= state_d;
      exp_q <= exp_d;
      good_q <= good_d;
      bad_q <= bad_d;
      seeded_q <= seeded_d;
      word_q <= word_d;
      err_q <= err_d;
      loss_q <= loss_d;
      code_q <= code_d;
    end
  end
  assign locked = state_q == LOCKED;
  assign state = state_q;
  assign word_count = word_q;
  assign err_count = err_q;
  assign loss_count = loss_q;
  assign code_err_count = code_q;
endmodule

// File: tb/tb_gtx_lane_checker.sv
// tb_gtx_lane_checker: directed lock, error, slip, wrap, resetdone and clear scenarios with hand-computed expectations.
module tb_gtx_lane_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] rx_data = '0;
  logic [1:0] rx_charisk = '0;
  logic [1:0] rx_disperr = '0;
  logic [1:0] rx_notintable = '0;
  logic rx_resetdone = 1'b1;
  logic clr_counts = 1'b0;
  logic locked;
  logic [1:0] state;
  logic [31:0] word_count, err_count, code_err_count;
  logic [15:0] loss_count;
  int checks = 0;
  int errors = 0;
  gtx_lane_checker dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_charisk(rx_charisk),
    .rx_disperr(rx_disperr), .rx_notintable(rx_notintable), .rx_resetdone(rx_resetdone),
    .clr_counts(clr_counts), .locked(locked), .state(state), .word_count(word_count),
    .err_count(err_count), .loss_count(loss_count), .code_err_count(code_err_count)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  task automatic send(input logic [15:0] d, input logic [1:0] k);
    rx_data = d;
    rx_charisk = k;
    @(posedge clk);
    #1;
  endtask
  task automatic comma();
    send(16'h50BC, 2'b01);
  endtask
  task automatic run(input int a, input int b);
    for (int i = a; i <= b; i++) send(16'(i), 2'b00);
  endtask
  initial begin
    rx_data = 16'hDEAD;
    rx_charisk = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_state", 32'(state), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_word", word_count, 0);
    check("rst_err", err_count, 0);
    check("rst_loss", 32'(loss_count), 0);
    check("rst_code", code_err_count, 0);
    send(16'h0005, 2'b00);
    check("hunt_ignores_data", 32'(state), 0);
    comma();
    check("comma_to_sync", 32'(state), 1);
    run(0, 14);
    check("sync_15_words", 32'(locked), 0);
    send(16'h000F, 2'b00);
    check("lock_after_16", 32'(locked), 1);
    check("lock_state", 32'(state), 2);
    check("lock_word0", word_count, 0);
    run(16'h10, 16'h13);
    check("word_after_13", word_count, 4);
    check("err_after_13", err_count, 0);
    run(16'h14, 16'hFF);
    send(16'h1234, 2'b00);
    run(16'h101, 16'h103);
    check("single_err", err_count, 1);
    check("single_err_locked", 32'(locked), 1);
    check("single_err_loss", 32'(loss_count), 0);
    check("single_err_word", word_count, 244);
    comma();
    send(16'h0104, 2'b00);
    check("comma_idle_word", word_count, 245);
    check("comma_idle_err", err_count, 1);
    run(16'h109, 16'h10B);
    check("slip3_locked", 32'(locked), 1);
    check("slip3_err", err_count, 4);
    send(16'h010C, 2'b00);
    check("slip4_err", err_count, 5);
    check("slip4_state", 32'(state), 0);
    check("slip4_loss", 32'(loss_count), 1);
    check("slip4_word", word_count, 249);
    send(16'h0000, 2'b11);
    check("hunt_ignores_bad", err_count, 5);
    comma();
    run(16'h200, 16'h20F);
    check("relock_state", 32'(state), 2);
    check("relock_word", word_count, 249);
    send(16'h0210, 2'b10);
    check("kbad_err", err_count, 6);
    check("kbad_word", word_count, 250);
    send(16'h0210, 2'b00);
    check("after_kbad_err", err_count, 6);
    check("after_kbad_word", word_count, 251);
    rst = 1'b1;
    send(16'h0211, 2'b00);
    rst = 1'b0;
    check("midlock_rst_state", 32'(state), 0);
    check("midlock_rst_word", word_count, 0);
    check("midlock_rst_err", err_count, 0);
    check("midlock_rst_loss", 32'(loss_count), 0);
    comma();
    run(16'hFFF0, 16'hFFFE);
    check("wrap_prelock", 32'(locked), 0);
    send(16'hFFFF, 2'b00);
    check("wrap_lock", 32'(locked), 1);
    run(0, 1);
    check("wrap_err", err_count, 0);
    check("wrap_word", word_count, 2);
    rx_resetdone = 1'b0;
    send(16'h0002, 2'b00);
    rx_resetdone = 1'b1;
    check("rdone_state", 32'(state), 0);
    check("rdone_loss", 32'(loss_count), 1);
    check("rdone_word", word_count, 2);
    comma();
    run(16'h300, 16'h30F);
    check("relock2_state", 32'(state), 2);
    clr_counts = 1'b1;
    send(16'h0999, 2'b00);
    clr_counts = 1'b0;
    check("clr_word", word_count, 0);
    check("clr_err", err_count, 0);
    check("clr_loss", 32'(loss_count), 0);
    check("clr_state", 32'(state), 2);
    send(16'h0311, 2'b00);
    check("post_clr_word", word_count, 1);
    check("post_clr_err", err_count, 0);
    rx_disperr = 2'b10;
    rx_notintable = 2'b01;
    send(16'h0312, 2'b00);
    rx_disperr = 2'b00;
    rx_notintable = 2'b00;
`ifdef GTX_LANE_CHECKER_CODEERR_EN
    check("codeerr_err", err_count, 1);
    check("codeerr_code", code_err_count, 1);
`else
    check("codeerr_err", err_count, 0);
    check("codeerr_code", code_err_count, 0);
`endif
    check("codeerr_word", word_count, 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
